// File: rtl/l2_probe_scheduler_pkg.sv
// Shared constants and types for the L2 probe scheduler.
//   TL_B_PROBE_BLOCK : Channel B opcode driven on every probe.
//   CAP_*            : cap-permission encodings carried on b_param.
//   ps_state_e       : scheduler FSM states.
package l2_probe_scheduler_pkg;

  localparam logic [2:0] TL_B_PROBE_BLOCK = 3'd6;

  localparam logic [1:0] CAP_TOT = 2'd0;
  localparam logic [1:0] CAP_TOB = 2'd1;
  localparam logic [1:0] CAP_TON = 2'd2;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_ISSUE   = 2'd1,
    PS_COLLECT = 2'd2,
    PS_DONE    = 2'd3
  } ps_state_e;

endpackage

// File: rtl/l2_probe_scheduler_if.sv
// Bundle of the probe scheduler's controller, Channel B and ack signals.
//   slave  : the scheduler (receives requests, drives probes/completion).
//   master : the controller / L1 side driving requests, b_ready and acks.
interface l2_probe_scheduler_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32
);
  // controller request
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_MASTERS-1:0] req_sharers;
  logic [NUM_MASTERS-1:0] req_exclude;
  logic [1:0]             req_cap;
  // Channel B
  logic [NUM_MASTERS-1:0] b_valid;
  logic [NUM_MASTERS-1:0] b_ready;
  logic [2:0]             b_opcode;
  logic [1:0]             b_param;
  logic [ADDR_WIDTH-1:0]  b_address;
  // decoded Channel C acks
  logic [NUM_MASTERS-1:0] ack_valid;
  logic [NUM_MASTERS-1:0] ack_data;
  logic [NUM_MASTERS-1:0] ack_ready;
  // completion
  logic                   done_valid;
  logic                   done_ready;
  logic                   done_dirty;
  logic [NUM_MASTERS-1:0] done_acked;
  logic                   done_timeout;
  logic                   busy;

  modport slave (
    input  req_valid, req_addr, req_sharers, req_exclude, req_cap,
           b_ready, ack_valid, ack_data, done_ready,
    output req_ready, b_valid, b_opcode, b_param, b_address,
           ack_ready, done_valid, done_dirty, done_acked, done_timeout, busy
  );

  modport master (
    output req_valid, req_addr, req_sharers, req_exclude, req_cap,
           b_ready, ack_valid, ack_data, done_ready,
    input  req_ready, b_valid, b_opcode, b_param, b_address,
           ack_ready, done_valid, done_dirty, done_acked, done_timeout, busy
  );
endinterface

// File: rtl/tidc_lowest_oh.sv
// Combinational lowest-set-bit picker: y = x & -x (one-hot, or zero when x==0).
//   x : candidate mask
//   y : one-hot of the lowest set bit of x
module tidc_lowest_oh #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);
  assign y = x & (~x + N'(1));
endmodule

// File: rtl/l2_probe_scheduler.sv
// L2 probe scheduler: issues one ProbeBlock per targeted L1 (lowest index
// first) on Channel B, collects ProbeAck/ProbeAckData on the decoded C path,
// and reports acked mask, dirty flag and timeout to the L2 controller.
//   clk, rst_n : clock, async active-low reset
//   pif        : request / Channel B / ack / completion bundle (slave side)
module l2_probe_scheduler
  import l2_probe_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  l2_probe_scheduler_if.slave pif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  ps_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0] target_q, target_d;
  logic [NUM_MASTERS-1:0] sent_q, sent_d;
  logic [NUM_MASTERS-1:0] acked_q, acked_d;
  logic                   dirty_q, dirty_d;
  logic                   timeout_q, timeout_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             cap_q, cap_d;

  logic [NUM_MASTERS-1:0] pick;
  logic [NUM_MASTERS-1:0] b_valid;
  logic [NUM_MASTERS-1:0] ack_ready;
  logic [NUM_MASTERS-1:0] hs;
  logic [NUM_MASTERS-1:0] acc;
  logic [NUM_MASTERS-1:0] req_target;

  tidc_lowest_oh #(.N(NUM_MASTERS)) u_pick (
    .x (target_q & ~sent_q),
    .y (pick)
  );

  // Both strobes decode registered state only, so no input reaches b_valid
  // combinationally and an ack cannot be taken in its own probe's cycle.
  assign b_valid    = (state_q == PS_ISSUE) ? pick : '0;
  assign ack_ready  = (state_q == PS_ISSUE || state_q == PS_COLLECT) ? (sent_q & ~acked_q) : '0;
  assign hs         = b_valid & pif.b_ready;
  assign acc        = pif.ack_valid & ack_ready;
  assign req_target = pif.req_sharers & ~pif.req_exclude;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sent_d    = sent_q;
    acked_d   = acked_q;
    dirty_d   = dirty_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cap_d     = cap_q;

    // Ack bookkeeping is shared by ISSUE and COLLECT; acc is zero elsewhere.
    acked_d = acked_q | acc;
    dirty_d = dirty_q | (|(acc & pif.ack_data));

    case (state_q)
      PS_IDLE: begin
        if (pif.req_valid) begin
          target_d  = req_target;
          addr_d    = pif.req_addr;
          cap_d     = pif.req_cap;
          sent_d    = '0;
          acked_d   = '0;
          dirty_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = (req_target == '0) ? PS_DONE : PS_ISSUE;
        end
      end
      PS_ISSUE: begin
        sent_d = sent_q | hs;
        if (acc != '0) cnt_d = '0;
        if ((target_q & ~sent_d) == '0)
          state_d = (acked_d == target_q) ? PS_DONE : PS_COLLECT;
      end
      PS_COLLECT: begin
        if (acc != '0)
          cnt_d = '0;
        else if (cnt_q != CNT_SAT)
          cnt_d = cnt_q + CW'(1);
        if (acked_d == target_q) begin
          state_d = PS_DONE;
        end else if (acc == '0 && cnt_q == CNT_LAST) begin
          state_d   = PS_DONE;
          timeout_d = 1'b1;
        end
      end
      PS_DONE: begin
        if (pif.done_ready) state_d = PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PS_IDLE;
      target_q  <= '0;
      sent_q    <= '0;
      acked_q   <= '0;
      dirty_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      cap_q     <= CAP_TOT;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      sent_q    <= sent_d;
      acked_q   <= acked_d;
      dirty_q   <= dirty_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cap_q     <= cap_d;
    end
  end

  // Completion fields are masked outside DONE so they read zero while idle.
  assign pif.req_ready    = (state_q == PS_IDLE);
  assign pif.busy         = (state_q != PS_IDLE);
  assign pif.b_valid      = b_valid;
  assign pif.b_opcode     = TL_B_PROBE_BLOCK;
  assign pif.b_param      = cap_q;
  assign pif.b_address    = addr_q;
  assign pif.ack_ready    = ack_ready;
  assign pif.done_valid   = (state_q == PS_DONE);
  assign pif.done_dirty   = (state_q == PS_DONE) & dirty_q;
  assign pif.done_acked   = (state_q == PS_DONE) ? acked_q : '0;
  assign pif.done_timeout = (state_q == PS_DONE) & timeout_q;

endmodule

// File: tb/tb_l2_probe_scheduler.sv
// Directed bench for l2_probe_scheduler (4 masters, TIMEOUT_CYCLES=8).
module tb_l2_probe_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  l2_probe_scheduler_if #(.NUM_MASTERS(4), .ADDR_WIDTH(32)) pif ();

  l2_probe_scheduler #(
    .NUM_MASTERS(4), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [3:0] sh, input logic [3:0] ex,
                         input logic [1:0] cap, input logic [31:0] addr);
    pif.req_valid   = 1'b1;
    pif.req_sharers = sh;
    pif.req_exclude = ex;
    pif.req_cap     = cap;
    pif.req_addr    = addr;
    step();
    pif.req_valid   = 1'b0;
  endtask

  task automatic retire();
    pif.done_ready = 1'b1;
    step();
    pif.done_ready = 1'b0;
    chk("retire_req_ready", 32'(pif.req_ready), 32'd1);
    chk("retire_done_valid", 32'(pif.done_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(pif.req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(pif.busy), 32'd0);
    chk({tag, "_b_valid"}, 32'(pif.b_valid), 32'd0);
    chk({tag, "_ack_ready"}, 32'(pif.ack_ready), 32'd0);
    chk({tag, "_done_valid"}, 32'(pif.done_valid), 32'd0);
    chk({tag, "_done_dirty"}, 32'(pif.done_dirty), 32'd0);
    chk({tag, "_done_acked"}, 32'(pif.done_acked), 32'd0);
    chk({tag, "_done_timeout"}, 32'(pif.done_timeout), 32'd0);
    chk({tag, "_b_param"}, 32'(pif.b_param), 32'd0);
    chk({tag, "_b_address"}, pif.b_address, 32'd0);
    chk({tag, "_b_opcode"}, 32'(pif.b_opcode), 32'd6);
  endtask

  initial begin
    pif.req_valid = 0; pif.req_addr = 0; pif.req_sharers = 0; pif.req_exclude = 0;
    pif.req_cap = 0; pif.b_ready = 0; pif.ack_valid = 0; pif.ack_data = 0;
    pif.done_ready = 0;

    // ---- reset ----
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // ---- basic: target m1,m3, cap toN ----
    pif.b_ready = 4'hF;
    request(4'b1011, 4'b0001, 2'd2, 32'h1000);
    chk("basic_b_valid_m1", 32'(pif.b_valid), 32'b0010);
    chk("basic_b_param", 32'(pif.b_param), 32'd2);
    chk("basic_b_address", pif.b_address, 32'h1000);
    chk("basic_busy", 32'(pif.busy), 32'd1);
    chk("basic_req_ready", 32'(pif.req_ready), 32'd0);
    step();
    chk("basic_b_valid_m3", 32'(pif.b_valid), 32'b1000);
    chk("basic_ack_ready_issue", 32'(pif.ack_ready), 32'b0010);
    step();
    chk("basic_b_valid_idle", 32'(pif.b_valid), 32'd0);
    chk("basic_ack_ready_collect", 32'(pif.ack_ready), 32'b1010);
    pif.ack_valid = 4'b1000; pif.ack_data = 4'b1000;
    step();
    pif.ack_valid = 0; pif.ack_data = 0;
    chk("basic_ack_ready_after_m3", 32'(pif.ack_ready), 32'b0010);
    chk("basic_not_done", 32'(pif.done_valid), 32'd0);
    pif.ack_valid = 4'b0010;
    step();
    pif.ack_valid = 0;
    chk("basic_done_valid", 32'(pif.done_valid), 32'd1);
    chk("basic_done_acked", 32'(pif.done_acked), 32'b1010);
    chk("basic_done_dirty", 32'(pif.done_dirty), 32'd1);
    chk("basic_done_timeout", 32'(pif.done_timeout), 32'd0);
    step();
    chk("basic_done_hold", 32'(pif.done_valid), 32'd1);
    chk("basic_acked_hold", 32'(pif.done_acked), 32'b1010);
    retire();

    // ---- empty target ----
    request(4'b0100, 4'b0100, 2'd0, 32'h3000);
    chk("empty_done_valid", 32'(pif.done_valid), 32'd1);
    chk("empty_done_acked", 32'(pif.done_acked), 32'd0);
    chk("empty_b_valid", 32'(pif.b_valid), 32'd0);
    retire();

    // ---- backpressure on m2, target m1,m2,m3 ----
    pif.b_ready = 4'b1011;
    request(4'b1110, 4'b0000, 2'd1, 32'h2040);
    chk("bp_b_valid_m1", 32'(pif.b_valid), 32'b0010);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_b_valid_hold", 32'(pif.b_valid), 32'b0100);
      chk("bp_b_address_hold", pif.b_address, 32'h2040);
      if (i < 4) step();
    end
    pif.b_ready = 4'hF;
    step();
    chk("bp_b_valid_m3", 32'(pif.b_valid), 32'b1000);
    chk("bp_b_param", 32'(pif.b_param), 32'd1);
    chk("bp_ack_ready_issue", 32'(pif.ack_ready), 32'b0110);
    // m3 acks in the same cycle as its probe handshake: must not be taken
    pif.ack_valid = 4'b1000;
    step();
    pif.ack_valid = 0;
    chk("corner_same_cycle_not_taken", 32'(pif.ack_ready), 32'b1110);
    chk("corner_b_valid_collect", 32'(pif.b_valid), 32'd0);
    // spurious m0 together with simultaneous m1+m2 acks
    pif.ack_valid = 4'b0111;
    chk("corner_spurious_m0_ready", 32'(pif.ack_ready[0]), 32'd0);
    step();
    pif.ack_valid = 0;
    chk("corner_multi_ack", 32'(pif.ack_ready), 32'b1000);
    chk("corner_not_done", 32'(pif.done_valid), 32'd0);
    // duplicate from m1 is ignored
    pif.ack_valid = 4'b0010; pif.ack_data = 4'b0010;
    step();
    pif.ack_valid = 0; pif.ack_data = 0;
    chk("corner_dup_ignored", 32'(pif.ack_ready), 32'b1000);
    chk("corner_dup_not_done", 32'(pif.done_valid), 32'd0);
    pif.ack_valid = 4'b1000;
    step();
    pif.ack_valid = 0;
    chk("corner_done_valid", 32'(pif.done_valid), 32'd1);
    chk("corner_done_acked", 32'(pif.done_acked), 32'b1110);
    chk("corner_done_dirty", 32'(pif.done_dirty), 32'd0);
    chk("corner_done_timeout", 32'(pif.done_timeout), 32'd0);
    retire();

    // ---- timeout: m1 acks (dirty) during ISSUE, m2 never acks ----
    request(4'b0110, 4'b0000, 2'd2, 32'h4000);
    chk("to_b_valid_m1", 32'(pif.b_valid), 32'b0010);
    step();
    chk("to_b_valid_m2", 32'(pif.b_valid), 32'b0100);
    pif.ack_valid = 4'b0010; pif.ack_data = 4'b0010;
    step();
    pif.ack_valid = 0; pif.ack_data = 0;
    chk("to_ack_ready_collect", 32'(pif.ack_ready), 32'b0100);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("to_not_yet", 32'(pif.done_valid), 32'd0);
    end
    step();
    chk("to_done_valid", 32'(pif.done_valid), 32'd1);
    chk("to_done_timeout", 32'(pif.done_timeout), 32'd1);
    chk("to_done_acked", 32'(pif.done_acked), 32'b0010);
    chk("to_done_dirty", 32'(pif.done_dirty), 32'd1);
    retire();

    // ---- reset mid-operation ----
    request(4'b0011, 4'b0000, 2'd1, 32'hABC0);
    step(); step();
    chk("rst_pre_busy", 32'(pif.busy), 32'd1);
    chk("rst_pre_ack_ready", 32'(pif.ack_ready), 32'b0011);
    chk("rst_pre_b_param", 32'(pif.b_param), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    chk("rst_post_req_ready", 32'(pif.req_ready), 32'd1);
    chk("rst_post_b_valid", 32'(pif.b_valid), 32'd0);
    // next transaction probes only its own target; nothing is replayed
    request(4'b1000, 4'b0000, 2'd0, 32'h5000);
    chk("rst_no_replay", 32'(pif.b_valid), 32'b1000);
    chk("rst_new_addr", pif.b_address, 32'h5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
